// File: rtl/z80_capture_pkg.sv
// z80_capture_pkg -- shared definitions for the Z80 bus capture block.
//
// Holds the bus-cycle type encoding, record field widths, the record width
// for both build variants and the default record FIFO depth.
//
// Build option: define Z80_CAPTURE_TIMESTAMP_EN to prepend a 16-bit
// timestamp to every record (REC_W becomes REC_W_TS instead of REC_W_BASE).
package z80_capture_pkg;

  localparam int TYPE_W = 3;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int TS_W   = 16;

  // Record layout, LSB first: data[7:0], addr[23:8], type[26:24], [ts[42:27]]
  localparam int REC_W_BASE = TYPE_W + ADDR_W + DATA_W;
  localparam int REC_W_TS   = TS_W + REC_W_BASE;

`ifdef Z80_CAPTURE_TIMESTAMP_EN
  localparam int REC_W = REC_W_TS;
`else
  localparam int REC_W = REC_W_BASE;
`endif

  localparam int DEFAULT_DEPTH = 8;

  // Bus-cycle types carried in the record; 6 and 7 are reserved.
  typedef enum logic [TYPE_W-1:0] {
    CYC_FETCH  = 3'd0,
    CYC_MEM_RD = 3'd1,
    CYC_MEM_WR = 3'd2,
    CYC_IO_RD  = 3'd3,
    CYC_IO_WR  = 3'd4,
    CYC_INTA   = 3'd5
  } cyc_type_e;

  // Classify the current bus cycle from the active-low control pins.
  // Only meaningful while the cycle is active. Interrupt acknowledge
  // (M1 together with IORQ) is tested first because it also has M1 low,
  // and opcode fetch is tested before plain memory read because a fetch
  // also drives RD low.
  function automatic cyc_type_e decode_type(
    input logic m1_n,
    input logic mreq_n,
    input logic iorq_n,
    input logic wr_n
  );
    cyc_type_e t;
    t = CYC_FETCH;
    if (!m1_n && !iorq_n) begin
      t = CYC_INTA;
    end else if (!m1_n && !mreq_n) begin
      t = CYC_FETCH;
    end else if (!mreq_n) begin
      t = wr_n ? CYC_MEM_RD : CYC_MEM_WR;
    end else if (!iorq_n) begin
      t = wr_n ? CYC_IO_RD : CYC_IO_WR;
    end
    return t;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// capture_fifo -- first-word-fall-through record FIFO.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request and record to store
//   pop           read request; ignored while empty
//   rdata         head record (zero while empty)
//   valid         FIFO not empty
//   level         number of stored entries, 0..DEPTH
//   drop          push refused because the FIFO was full and not popping
//
// Handshake: an entry leaves at an edge where valid & pop; a new entry
// is accepted at an edge where push & (not full or leaving at the same
// edge). A push into an empty FIFO is stored, never bypassed, so it
// appears on rdata one cycle later.
module capture_fifo
  import z80_capture_pkg::*;
#(
  parameter int WIDTH = REC_W_BASE,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   drop
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (level != '0);
  assign full    = (level == LEVEL_W'(DEPTH));
  assign pop_ok  = pop & valid;
  // A full FIFO that is popping at the same edge still has room.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; rdata is forced to zero while empty so
  // stale contents never show on the output.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/z80_bus_capture.sv
// z80_bus_capture -- passive Z80 bus monitor that records completed bus
// cycles into a FIFO.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock and synchronous active-high reset; the Z80
//                        pins are synchronous to wb_clk_i
//   en                   capture enable; completions are discarded while low
//   m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n
//                        Z80 control pins, active-low
//   addr[15:0], dbus[7:0] Z80 address and data bus
//   rec_valid            a record is available
//   rec_data             head record {[ts], type[2:0], addr[15:0], data[7:0]}
//   rec_ready            consume the head record when rec_valid is high
//   level                number of buffered records
//   ovf_cnt              saturating count of records dropped on a full FIFO
//   ovf_clr              clears ovf_cnt (wins over a simultaneous drop)
//
// Handshake: rec_data is first-word-fall-through; a record is consumed at
// every edge where rec_valid and rec_ready are both high.
//
// Build option: Z80_CAPTURE_TIMESTAMP_EN adds a 16-bit free-running
// counter; each record then carries its completion-edge count in [42:27].
module z80_bus_capture
  import z80_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH  // power of two, at least 2
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   en,
  input  logic                   m1_n,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   rfsh_n,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      dbus,
  output logic                   rec_valid,
  output logic [REC_W-1:0]       rec_data,
  input  logic                   rec_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             ovf_cnt,
  input  logic                   ovf_clr
);

  logic              active;
  logic              active_q;
  logic              completion;
  logic              push;
  logic              drop;
  logic [TYPE_W-1:0] cap_type;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [REC_W-1:0]  push_rec;

  // A memory cycle counts only outside refresh, so refresh cycles never
  // become records. An M1 with IORQ is an interrupt acknowledge, which
  // drives neither RD nor WR.
  assign active = (~mreq_n & rfsh_n & (~rd_n | ~wr_n)) |
                  (~iorq_n & (~rd_n | ~wr_n | ~m1_n));

  // The cycle ends on the first edge where it is no longer active; the
  // captured fields then hold the last sample taken while it was active.
  assign completion = active_q & ~active;

  // While en is low active_q keeps tracking, but nothing reaches the FIFO,
  // so no drop can be counted either.
  assign push = completion & en;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      active_q <= 1'b0;
      cap_type <= '0;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      active_q <= active;
      if (active) begin
        cap_type <= decode_type(m1_n, mreq_n, iorq_n, wr_n);
        cap_addr <= addr;
        cap_data <= dbus;
      end
    end
  end

  // Drop counter saturates at 255; a clear at the same edge as a drop wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

`ifdef Z80_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running from reset; the value stamped is the one present at the
  // completion edge, before this edge's increment.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  assign push_rec = {ts_cnt, cap_type, cap_addr, cap_data};
`else
  assign push_rec = {cap_type, cap_addr, cap_data};
`endif

  capture_fifo #(
    .WIDTH(REC_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .push (push),
    .wdata(push_rec),
    .pop  (rec_ready),
    .rdata(rec_data),
    .valid(rec_valid),
    .level(level),
    .drop (drop)
  );

endmodule

// File: doc/z80_bus_capture.md
Z80_BUS_CAPTURE -- requirements
Module: z80_bus_capture

Interface
REQ-001 Parameter: DEPTH, 8, record FIFO depth in entries; power of two, minimum 2.
REQ-002 wb_clk_i  in  1  single clock; Z80 pins are synchronous to it, so no synchronizers.
REQ-003 wb_rst_i  in  1  reset; synchronous, active-high.
REQ-004 en  in  1  capture enable; pushes are suppressed while low.
REQ-005 m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  Z80 control pins, active-low.
REQ-006 addr  in  16  Z80 address bus.
REQ-007 dbus  in  8  Z80 data bus as seen at the pads (read data or write data).
REQ-008 rec_valid  out  1  FIFO not empty.
REQ-009 rec_data  out  27 (43 with timestamp)  head record: {[ts], type[2:0], addr[15:0], data[7:0]}, first-word-fall-through.
REQ-010 rec_ready  in  1  pop the head record when rec_valid is high.
REQ-011 level  out  $clog2(DEPTH)+1  current number of FIFO entries.
REQ-012 ovf_cnt  out  8  count of dropped records, saturating; ovf_clr  in  1  clears it.

Function
REQ-013 active = (!mreq_n & rfsh_n & (!rd_n | !wr_n)) | (!iorq_n & (!rd_n | !wr_n | !m1_n)).
REQ-014 Refresh cycles (rfsh_n low) shall never produce a record.
REQ-015 On each edge with active=1, register addr, dbus and type; the last sample before deassertion is the one recorded.
REQ-016 Type encoding: 0 fetch (!m1_n & !mreq_n), 1 mem read, 2 mem write, 3 IO read, 4 IO write, 5 interrupt acknowledge (!m1_n & !iorq_n); 6 and 7 are reserved.
REQ-017 Completion: an edge where the registered active_q=1 and the current active=0; the push occurs at that same edge.
REQ-018 A pushed record is visible on rec_valid/rec_data in the cycle immediately after the completion edge.
REQ-019 A pop occurs at an edge where rec_valid & rec_ready; rec_ready is ignored while empty.
REQ-020 Push while full without a simultaneous pop: drop the record and increment ovf_cnt, saturating at 255.
REQ-021 Push and pop at the same edge while full: both accepted, level unchanged, no drop.
REQ-022 Push and pop at the same edge while empty: the record enters, level becomes 1 (no bypass).
REQ-023 ovf_clr coincident with a drop: ovf_cnt becomes 0 (clear wins).
REQ-024 en=0: active_q keeps tracking the bus; completions are neither pushed nor counted as drops.
REQ-025 FIFO pointers wrap modulo DEPTH; level ranges 0..DEPTH.

Reset
REQ-026 On reset: level=0, rec_valid=0, rec_data=0, ovf_cnt=0, active_q=0, captured fields=0, timestamp=0.
REQ-027 A bus cycle active across reset release shall be recorded on completion, using values sampled after release; a cycle ending during reset is lost.

Configuration
REQ-028 With Z80_CAPTURE_TIMESTAMP_EN defined: a 16-bit free-running counter counts from reset and wraps 0xFFFF->0x0000; each record carries the counter value at its completion edge in bits [42:27].
REQ-029 Without Z80_CAPTURE_TIMESTAMP_EN: the counter is absent and rec_data is 27 bits.

Structure
REQ-030 Package z80_capture_pkg holds the type encodings, field widths, record width (both variants) and the default DEPTH.
REQ-031 FIFO storage and pointers live in sub-module capture_fifo (parameterised width and depth); detection and capture logic stay in the top.

Verification
REQ-032 Fetch at 0x0000 with opcode 0x3E, rd_n rising -> one record {0, 0x0000, 0x3E} visible the next cycle; level=1.
REQ-033 Memory write of 0x1D to 0xAA20 -> record {2, 0xAA20, 0x1D}; a refresh cycle in between -> no record.
REQ-034 IO write of 0x55 to 0x00FE, then interrupt acknowledge with bus 0xFF -> records {4, 0x00FE, 0x55} then {5, addr, 0xFF}.
REQ-035 DEPTH+3 completions with rec_ready=0 -> level=DEPTH, ovf_cnt=3; then pop and push together -> level=DEPTH, ovf_cnt=3.
REQ-036 Reset asserted mid-write and released while wr_n is still low -> FIFO empty after reset, exactly one record afterwards, with post-release data.
REQ-037 With the macro defined, two fetches 4 cycles apart -> timestamp delta=4; counter at 0xFFFE plus 3 cycles reads 0x0001.
